// File: rtl/tag_array_ctrl_pkg.sv
// Shared constants and state encoding for the tag array controller.
package tag_array_ctrl_pkg;

    localparam int SETS   = 64;
    localparam int WAYS   = 8;
    localparam int TAG_W  = 23;
    localparam int SET_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int MASK_W = WAYS;
    localparam int ROW_W  = WAYS * TAG_W;

    // INIT and FLUSH both sweep the array.
    // DRAIN is a one-cycle gap so that a read accepted just before a flush
    // can still complete.
    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/tag_array_ctrl_sweep.sv
// Set-index counter shared by the initialisation and flush sweeps.
module tag_sweep_counter
    import tag_array_ctrl_pkg::*;
#(
    parameter int N_SETS = SETS
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      clr,
    input  logic                      en,
    output logic [$clog2(N_SETS)-1:0] count,
    output logic                      last
);

    localparam int CNT_W = $clog2(N_SETS);

    logic [CNT_W-1:0] count_reg;

    // Advance one set per enabled cycle; wrap to 0 after the last set.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= last ? '0 : count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == CNT_W'(N_SETS - 1));

endmodule

// File: rtl/tag_array_ctrl.sv
// Tag array controller: clears the array after reset and on flush, and
// arbitrates refill writes and lookup reads onto a 1R1W tag array.
module tag_array_ctrl
    import tag_array_ctrl_pkg::*;
#(
    parameter int P_SETS  = SETS,
    parameter int P_WAYS  = WAYS,
    parameter int P_TAG_W = TAG_W
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          rd_req_valid,
    input  logic [$clog2(P_SETS)-1:0]     rd_req_set,
    output logic                          rd_req_ready,
    output logic                          rd_resp_valid,
    output logic [P_WAYS*P_TAG_W-1:0]     rd_resp_tags,
    input  logic                          wr_req_valid,
    input  logic [$clog2(P_SETS)-1:0]     wr_req_set,
    input  logic [$clog2(P_WAYS)-1:0]     wr_req_way,
    input  logic [P_TAG_W-1:0]            wr_req_tag,
    output logic                          wr_req_ready,
    input  logic                          flush_req,
    output logic                          busy,
    output logic [$clog2(P_SETS)-1:0]     arr_R0_addr,
    output logic                          arr_R0_en,
    input  logic [P_WAYS*P_TAG_W-1:0]     arr_R0_data,
    output logic [$clog2(P_SETS)-1:0]     arr_W0_addr,
    output logic                          arr_W0_en,
    output logic [P_WAYS*P_TAG_W-1:0]     arr_W0_data,
    output logic [P_WAYS-1:0]             arr_W0_mask
);

    localparam int S_W = $clog2(P_SETS);
    localparam int W_W = $clog2(P_WAYS);
    localparam int R_W = P_WAYS * P_TAG_W;

    state_t           state_reg;
    state_t           state_next;
    logic             rd_resp_valid_reg;
    logic [S_W-1:0]   sweep_count;
    logic             sweep_last;
    logic             sweeping;
    logic             in_run;
    logic             rd_fire;
    logic             wr_fire;
    logic [R_W-1:0]   wr_tag_rep;
    logic [P_WAYS-1:0] wr_way_mask;

    assign sweeping = (state_reg == ST_INIT) || (state_reg == ST_FLUSH);
    assign in_run   = (state_reg == ST_RUN);

    tag_sweep_counter #(
        .N_SETS (P_SETS)
    ) u_sweep (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (state_reg == ST_DRAIN),
        .en      (sweeping),
        .count   (sweep_count),
        .last    (sweep_last)
    );

    // Refill data is the tag copied into every way; the mask picks the way.
    generate
        for (genvar gi = 0; gi < P_WAYS; gi++) begin : g_way
            assign wr_tag_rep[gi*P_TAG_W +: P_TAG_W] = wr_req_tag;
            assign wr_way_mask[gi] = (wr_req_way == W_W'(gi));
        end
    endgenerate

    // Handshakes: a flush request blocks both sides; a write beats a read to the same set.
    always_comb begin
        wr_req_ready = in_run && !flush_req;
        rd_req_ready = in_run && !flush_req &&
                       !(wr_req_valid && (wr_req_set == rd_req_set));
    end

    assign wr_fire = wr_req_valid && wr_req_ready;
    assign rd_fire = rd_req_valid && rd_req_ready;
    assign busy    = !in_run;

    // Next-state selection for the sweep / run / drain sequence.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_INIT:  if (sweep_last) state_next = ST_RUN;
            ST_RUN:   if (flush_req)  state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_FLUSH;
            ST_FLUSH: if (sweep_last) state_next = ST_RUN;
            default:  state_next = ST_INIT;
        endcase
    end

    // State register and read-response valid, one cycle behind the accepted read.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= ST_INIT;
            rd_resp_valid_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            rd_resp_valid_reg <= rd_fire;
        end
    end

    assign rd_resp_valid = rd_resp_valid_reg;
    assign rd_resp_tags  = arr_R0_data;

    // Array port drive: sweeps write zeros to every way, refills write one way.
    always_comb begin
        arr_R0_en   = rd_fire;
        arr_R0_addr = rd_fire ? rd_req_set : '0;
        arr_W0_en   = 1'b0;
        arr_W0_addr = '0;
        arr_W0_data = '0;
        arr_W0_mask = '0;
        if (sweeping) begin
            arr_W0_en   = 1'b1;
            arr_W0_addr = sweep_count;
            arr_W0_mask = '1;
        end else if (wr_fire) begin
            arr_W0_en   = 1'b1;
            arr_W0_addr = wr_req_set;
            arr_W0_data = wr_tag_rep;
            arr_W0_mask = wr_way_mask;
        end
    end

endmodule

// File: tb/tb_tag_array_ctrl.sv
// Scoreboard bench for tag_array_ctrl with a behavioural 1R1W tag array.
module tb_tag_array_ctrl;

    logic         clock;
    logic         reset_n;
    logic         rd_req_valid;
    logic [5:0]   rd_req_set;
    logic         rd_req_ready;
    logic         rd_resp_valid;
    logic [183:0] rd_resp_tags;
    logic         wr_req_valid;
    logic [5:0]   wr_req_set;
    logic [2:0]   wr_req_way;
    logic [22:0]  wr_req_tag;
    logic         wr_req_ready;
    logic         flush_req;
    logic         busy;
    logic [5:0]   arr_R0_addr;
    logic         arr_R0_en;
    logic [183:0] arr_R0_data;
    logic [5:0]   arr_W0_addr;
    logic         arr_W0_en;
    logic [183:0] arr_W0_data;
    logic [7:0]   arr_W0_mask;

    int n_cmp = 0;
    int n_bad = 0;
    logic [183:0] exp_q[$];
    logic [183:0] mem [64];

    tag_array_ctrl dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .rd_req_valid  (rd_req_valid),
        .rd_req_set    (rd_req_set),
        .rd_req_ready  (rd_req_ready),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_tags  (rd_resp_tags),
        .wr_req_valid  (wr_req_valid),
        .wr_req_set    (wr_req_set),
        .wr_req_way    (wr_req_way),
        .wr_req_tag    (wr_req_tag),
        .wr_req_ready  (wr_req_ready),
        .flush_req     (flush_req),
        .busy          (busy),
        .arr_R0_addr   (arr_R0_addr),
        .arr_R0_en     (arr_R0_en),
        .arr_R0_data   (arr_R0_data),
        .arr_W0_addr   (arr_W0_addr),
        .arr_W0_en     (arr_W0_en),
        .arr_W0_data   (arr_W0_data),
        .arr_W0_mask   (arr_W0_mask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural tag array: masked write, registered read.
    always @(posedge clock) begin
        if (arr_W0_en)
            for (int w = 0; w < 8; w++)
                if (arr_W0_mask[w])
                    mem[arr_W0_addr][w*23 +: 23] <= arr_W0_data[w*23 +: 23];
        if (arr_R0_en)
            arr_R0_data <= mem[arr_R0_addr];
    end

    task automatic check(input string name, input logic [183:0] act, input logic [183:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response is compared against the oldest expectation.
    always @(negedge clock) begin
        if (reset_n && rd_resp_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_resp: unexpected response %h, none expected", rd_resp_tags);
            end else begin
                logic [183:0] e;
                e = exp_q.pop_front();
                if (rd_resp_tags !== e) begin
                    n_bad++;
                    $display("FAIL rd_resp: got %h expected %h", rd_resp_tags, e);
                end
                $display("txn rd_resp tags=%h", rd_resp_tags);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // 64 sweep writes with requests pending (they must be refused), then RUN.
    task automatic sweep_check(input string name);
        logic [19:0] act;
        logic [19:0] exp;
        rd_req_valid = 1'b1; rd_req_set = 6'd63;
        wr_req_valid = 1'b1; wr_req_set = 6'd62; wr_req_way = 3'd1; wr_req_tag = 23'h1;
        for (int i = 0; i < 64; i++) begin
            act = {busy, arr_W0_en, arr_W0_addr, arr_W0_mask, |arr_W0_data,
                   rd_req_ready, wr_req_ready, arr_R0_en};
            exp = {1'b1, 1'b1, 6'(i), 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
            check($sformatf("%s_cycle%0d", name, i), 184'(act), 184'(exp));
            tick();
        end
        rd_req_valid = 1'b0; wr_req_valid = 1'b0;
        #1;
        check({name, "_done"}, 184'({busy, rd_req_ready, wr_req_ready, arr_W0_en}), 184'(4'b0110));
        $display("txn %s sweep complete", name);
    endtask

    // Single accepted read with hand-computed expected row.
    task automatic do_read(input logic [5:0] set, input logic [183:0] exp);
        rd_req_valid = 1'b1; rd_req_set = set;
        #1;
        check($sformatf("rd_accept_set%0d", set), 184'({rd_req_ready, arr_R0_en, arr_R0_addr}),
              184'({1'b1, 1'b1, set}));
        exp_q.push_back(exp);
        tick();
        rd_req_valid = 1'b0;
        $display("txn read set=%0d", set);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int s = 0; s < 64; s++) mem[s] = '1;
        reset_n = 1'b0;
        rd_req_valid = 0; rd_req_set = 0;
        wr_req_valid = 0; wr_req_set = 0; wr_req_way = 0; wr_req_tag = 0;
        flush_req = 0;
        #2;
        check("reset_state", 184'({busy, rd_resp_valid, rd_req_ready, wr_req_ready, arr_R0_en}),
              184'(5'b10000));
        repeat (3) tick();
        reset_n = 1'b1;
        sweep_check("init");

        // Refill set 5 way 3, then read it back.
        wr_req_valid = 1; wr_req_set = 6'd5; wr_req_way = 3'd3; wr_req_tag = 23'h12345;
        #1;
        check("wr5_ctrl", 184'({wr_req_ready, arr_W0_en, arr_W0_addr, arr_W0_mask}),
              184'({1'b1, 1'b1, 6'd5, 8'h08}));
        check("wr5_data", arr_W0_data, {8{23'h12345}});
        tick();
        wr_req_valid = 0;
        $display("txn write set=5 way=3 tag=12345");
        do_read(6'd5, 184'h12345 << 69);
        check("rd5_latency", 184'(rd_resp_valid), 184'(1));
        tick();
        check("rd5_valid_drop", 184'(rd_resp_valid), 184'(0));

        // Same-set conflict on set 9: write wins, read stalls one cycle.
        wr_req_valid = 1; wr_req_set = 6'd9; wr_req_way = 3'd0; wr_req_tag = 23'h7ABCD;
        rd_req_valid = 1; rd_req_set = 6'd9;
        #1;
        check("conflict_ready", 184'({wr_req_ready, rd_req_ready, arr_R0_en}), 184'(3'b100));
        tick();
        wr_req_valid = 0;
        $display("txn conflict write set=9");
        do_read(6'd9, 184'h7ABCD);

        // Read set 2 and write set 7 in the same cycle.
        rd_req_valid = 1; rd_req_set = 6'd2;
        wr_req_valid = 1; wr_req_set = 6'd7; wr_req_way = 3'd7; wr_req_tag = 23'h00FFF;
        #1;
        check("dual_ports", 184'({rd_req_ready, wr_req_ready, arr_R0_en, arr_W0_en, arr_W0_mask}),
              184'({4'b1111, 8'h80}));
        exp_q.push_back('0);
        tick();
        rd_req_valid = 0; wr_req_valid = 0;
        $display("txn read set=2 + write set=7");

        // Back-to-back reads.
        rd_req_valid = 1; rd_req_set = 6'd7;
        exp_q.push_back(184'h00FFF << 161);
        tick();
        rd_req_set = 6'd5;
        #1;
        check("b2b_second_ready", 184'({rd_req_ready, rd_resp_valid}), 184'(2'b11));
        exp_q.push_back(184'h12345 << 69);
        tick();
        rd_req_valid = 0;
        $display("txn back-to-back reads set=7,5");

        // Flush with a read in flight.
        do_read(6'd9, 184'h7ABCD);
        flush_req = 1;
        #1;
        check("flush_block", 184'({rd_req_ready, wr_req_ready}), 184'(0));
        tick();
        flush_req = 0;
        #1;
        check("drain", 184'({busy, rd_req_ready, wr_req_ready, arr_W0_en, arr_R0_en}), 184'(5'b10000));
        tick();
        sweep_check("flush");
        do_read(6'd5, '0);
        do_read(6'd9, '0);
        tick();

        // Reset in the middle of a flush sweep.
        flush_req = 1;
        tick();
        flush_req = 0;
        tick();
        repeat (30) tick();
        check("flush_at30", 184'({busy, arr_W0_en, arr_W0_addr}), 184'({2'b11, 6'd30}));
        reset_n = 0;
        #1;
        check("reset_midflush", 184'({busy, rd_resp_valid, arr_W0_addr}), 184'({2'b10, 6'd0}));
        repeat (2) tick();
        reset_n = 1;
        sweep_check("reinit");
        do_read(6'd7, '0);
        repeat (3) tick();

        check("queue_empty", 184'(exp_q.size()), 184'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
